// File: rtl/ped_request_conditioner_pkg.sv
// Shared types and defaults for the pedestrian request conditioner.
package ped_req_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PRESS_W         = 3;

  // Fixed encodings so legacy code that stores the state as raw bits still decodes it.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    DB_PRESS   = ST_DB_PRESS,
    HELD       = ST_HELD,
    DB_RELEASE = ST_DB_RELEASE
  } state_t;

endpackage

// File: rtl/ped_request_conditioner_if.sv
// Button/request bundle between the push-button side and the conditioner.
interface ped_request_conditioner_if
  import ped_req_pkg::*;
#(
  parameter int PRESS_W = DEF_PRESS_W
);

  logic               btn_i;
  logic               ack_i;
  logic               req_o;
  logic               btn_db_o;
  logic [PRESS_W-1:0] press_cnt_o;

  modport master (output btn_i, ack_i, input req_o, btn_db_o, press_cnt_o);
  modport slave  (input btn_i, ack_i, output req_o, btn_db_o, press_cnt_o);

endinterface

// File: rtl/ped_request_conditioner_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// Debounces the pedestrian button and turns each accepted press into a sticky
// request held until the light controller acknowledges it.
module ped_request_conditioner
  import ped_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int PRESS_W         = DEF_PRESS_W
) (
  input logic                      clk_i,
  input logic                      reset_ni,
  ped_request_conditioner_if.slave bus
);

  localparam logic [DB_W-1:0]    CNT_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRESS_W-1:0] PRESS_MAX = '1;

  logic btn_s;

  sync_2ff u_btn_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (bus.btn_i),
    .q_o      (btn_s)
  );

  state_t             state_q, state_d;
  logic               clr_cnt, inc_cnt, set_req;
  logic [DB_W-1:0]    cnt_q, cnt_d;
  logic               req_q, req_d;
  logic [PRESS_W-1:0] press_q, press_d;

  // Control unit: the counter is cleared on every state change so each
  // debounce window starts from zero.
  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    inc_cnt = 1'b0;
    set_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DB_PRESS;
          clr_cnt = 1'b1;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          clr_cnt = 1'b1;
          set_req = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = DB_RELEASE;
          clr_cnt = 1'b1;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
          clr_cnt = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr_cnt = 1'b1;
      end
    endcase
  end

  // Datapath: a new press wins over a coincident ack so it is never lost.
  always_comb begin
    cnt_d   = cnt_q;
    req_d   = req_q;
    press_d = press_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (inc_cnt) begin
      cnt_d = cnt_q + DB_W'(1);
    end
    if (set_req) begin
      req_d = 1'b1;
      if (bus.ack_i) begin
        press_d = PRESS_W'(1);
      end else if (press_q != PRESS_MAX) begin
        press_d = press_q + PRESS_W'(1);
      end
    end else if (bus.ack_i) begin
      req_d   = 1'b0;
      press_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      press_q <= press_d;
    end
  end

  assign bus.req_o       = req_q;
  assign bus.btn_db_o    = (state_q == HELD) || (state_q == DB_RELEASE);
  assign bus.press_cnt_o = press_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench: directed scenarios plus random button/ack traffic,
// all compared against a run-length reference model of the debounced button.
module tb_ped_request_conditioner;
  import ped_req_pkg::*;

  localparam int DEB       = DEF_DEBOUNCE_CYCLES;
  localparam int PW        = DEF_PRESS_W;
  localparam int PRESS_MAX = (1 << PW) - 1;

  logic clk_i;
  logic reset_ni;

  ped_request_conditioner_if #(.PRESS_W(PW)) bus ();

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .PRESS_W         (PW)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: two-cycle input delay line, then the debounced level flips
  // once the synchronised button has disagreed with it for DEB+1 edges in a row.
  bit mHist[2];
  bit mDb;
  int mRun;
  bit mReq;
  int mPress;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got still running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic model_reset();
    mHist[0] = 1'b0;
    mHist[1] = 1'b0;
    mDb      = 1'b0;
    mRun     = 0;
    mReq     = 1'b0;
    mPress   = 0;
  endtask

  task automatic tick();
    bit bs;
    bit accept;
    @(posedge clk_i);
    if (!reset_ni) begin
      model_reset();
    end else begin
      bs     = mHist[1];
      accept = 1'b0;
      if (bs != mDb) begin
        mRun++;
        if (mRun == DEB + 1) begin
          mDb    = bs;
          mRun   = 0;
          accept = bs;
        end
      end else begin
        mRun = 0;
      end
      if (accept) begin
        mReq   = 1'b1;
        mPress = bus.ack_i ? 1 : ((mPress < PRESS_MAX) ? mPress + 1 : PRESS_MAX);
      end else if (bus.ack_i) begin
        mReq   = 1'b0;
        mPress = 0;
      end
      mHist[1] = mHist[0];
      mHist[0] = bus.btn_i;
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    reset_ni   = 1'b0;
    bus.btn_i  = 1'b1;
    bus.ack_i  = 1'b0;
    model_reset();
    repeat (3) tick();
    nChecks++;
    if (bus.req_o !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_req: got %b expected 0", bus.req_o);
    end
    nChecks++;
    if (bus.btn_db_o !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_db: got %b expected 0", bus.btn_db_o);
    end
    nChecks++;
    if (bus.press_cnt_o !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_press: got %0d expected 0", bus.press_cnt_o);
    end
    bus.btn_i = 1'b0;
    reset_ni  = 1'b1;
  endtask

  task automatic test_clean_press();
    bus.btn_i = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      nChecks++;
      if (bus.req_o !== (e >= DEB + 3)) begin
        nErrors++;
        $display("[TB] FAIL clean_req edge %0d: got %b expected %b", e, bus.req_o, (e >= DEB + 3));
      end
      nChecks++;
      if (bus.btn_db_o !== mDb) begin
        nErrors++;
        $display("[TB] FAIL clean_db edge %0d: got %b expected %b", e, bus.btn_db_o, mDb);
      end
    end
    nChecks++;
    if (bus.press_cnt_o !== PW'(1)) begin
      nErrors++;
      $display("[TB] FAIL clean_press: got %0d expected 1", bus.press_cnt_o);
    end
    bus.btn_i = 1'b0;
    repeat (10) tick();
    nChecks++;
    if (bus.req_o !== 1'b1 || bus.btn_db_o !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL clean_after_release: got req=%b db=%b expected req=1 db=0", bus.req_o, bus.btn_db_o);
    end
  endtask

  task automatic test_glitch();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    bus.btn_i = 1'b1;
    repeat (3) tick();
    bus.btn_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nChecks++;
      if (bus.req_o !== 1'b0 || bus.btn_db_o !== 1'b0 || bus.press_cnt_o !== '0) begin
        nErrors++;
        $display("[TB] FAIL glitch cycle %0d: got req=%b db=%b press=%0d expected all 0",
                 i, bus.req_o, bus.btn_db_o, bus.press_cnt_o);
      end
    end
  endtask

  task automatic test_bouncy_release();
    bus.btn_i = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 10; i++) begin
      bus.btn_i = ((i / 2) % 2) == 1;
      tick();
      nChecks++;
      if (bus.btn_db_o !== mDb || bus.press_cnt_o !== PW'(1)) begin
        nErrors++;
        $display("[TB] FAIL bounce cycle %0d: got db=%b press=%0d expected db=%b press=1",
                 i, bus.btn_db_o, bus.press_cnt_o, mDb);
      end
    end
    bus.btn_i = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      nChecks++;
      if (bus.btn_db_o !== (j < 4)) begin
        nErrors++;
        $display("[TB] FAIL bounce_fall hold %0d: got db=%b expected %b", j, bus.btn_db_o, (j < 4));
      end
    end
    nChecks++;
    if (bus.press_cnt_o !== PW'(1) || bus.req_o !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL bounce_end: got press=%0d req=%b expected press=1 req=1", bus.press_cnt_o, bus.req_o);
    end
  endtask

  task automatic test_ack_races();
    bus.btn_i = 1'b1;
    for (int e = 1; e <= DEB + 3; e++) begin
      bus.ack_i = (e == DEB + 3);
      tick();
    end
    bus.ack_i = 1'b0;
    nChecks++;
    if (bus.req_o !== 1'b1 || bus.press_cnt_o !== PW'(1)) begin
      nErrors++;
      $display("[TB] FAIL ack_with_set: got req=%b press=%0d expected req=1 press=1", bus.req_o, bus.press_cnt_o);
    end
    bus.btn_i = 1'b0;
    repeat (8) tick();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    nChecks++;
    if (bus.req_o !== 1'b0 || bus.press_cnt_o !== '0) begin
      nErrors++;
      $display("[TB] FAIL ack_clear: got req=%b press=%0d expected req=0 press=0", bus.req_o, bus.press_cnt_o);
    end
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    tick();
    nChecks++;
    if (bus.req_o !== 1'b0 || bus.press_cnt_o !== '0) begin
      nErrors++;
      $display("[TB] FAIL ack_idle: got req=%b press=%0d expected req=0 press=0", bus.req_o, bus.press_cnt_o);
    end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 9; k++) begin
      bus.btn_i = 1'b1;
      repeat (8) tick();
      bus.btn_i = 1'b0;
      repeat (8) tick();
      nChecks++;
      if (int'(bus.press_cnt_o) !== ((k < PRESS_MAX) ? k : PRESS_MAX)) begin
        nErrors++;
        $display("[TB] FAIL sat_press press %0d: got %0d expected %0d",
                 k, bus.press_cnt_o, ((k < PRESS_MAX) ? k : PRESS_MAX));
      end
    end
    repeat (5) tick();
    nChecks++;
    if (int'(bus.press_cnt_o) !== PRESS_MAX || bus.req_o !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL sat_hold: got press=%0d req=%b expected press=%0d req=1", bus.press_cnt_o, bus.req_o, PRESS_MAX);
    end
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    nChecks++;
    if (bus.press_cnt_o !== '0 || bus.req_o !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL sat_ack: got press=%0d req=%b expected 0 0", bus.press_cnt_o, bus.req_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.btn_i = 1'b1;
    repeat (4) tick();
    #2 reset_ni = 1'b0;
    #1;
    nChecks++;
    if (bus.req_o !== 1'b0 || bus.btn_db_o !== 1'b0 || bus.press_cnt_o !== '0) begin
      nErrors++;
      $display("[TB] FAIL rst_debounce: got req=%b db=%b press=%0d expected all 0",
               bus.req_o, bus.btn_db_o, bus.press_cnt_o);
    end
    tick();
    reset_ni = 1'b1;
    repeat (DEB + 6) tick();
    nChecks++;
    if (bus.req_o !== 1'b1 || bus.btn_db_o !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL rst_setup: got req=%b db=%b expected 1 1", bus.req_o, bus.btn_db_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    nChecks++;
    if (bus.req_o !== 1'b0 || bus.btn_db_o !== 1'b0 || bus.press_cnt_o !== '0) begin
      nErrors++;
      $display("[TB] FAIL rst_pending: got req=%b db=%b press=%0d expected all 0",
               bus.req_o, bus.btn_db_o, bus.press_cnt_o);
    end
    tick();
    reset_ni = 1'b1;
    for (int e = 1; e <= DEB + 4; e++) begin
      tick();
      nChecks++;
      if (bus.req_o !== (e >= DEB + 3)) begin
        nErrors++;
        $display("[TB] FAIL rst_fresh edge %0d: got %b expected %b", e, bus.req_o, (e >= DEB + 3));
      end
    end
    bus.btn_i = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        bus.btn_i = $urandom_range(0, 1);
        hold      = $urandom_range(1, 9);
      end
      hold--;
      bus.ack_i = ($urandom_range(0, 7) == 0);
      tick();
      nChecks++;
      if (bus.req_o !== mReq || bus.btn_db_o !== mDb || int'(bus.press_cnt_o) !== mPress) begin
        nErrors++;
        $display("[TB] FAIL random cycle %0d: got req=%b db=%b press=%0d expected req=%b db=%b press=%0d",
                 c, bus.req_o, bus.btn_db_o, bus.press_cnt_o, mReq, mDb, mPress);
      end
    end
    bus.ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_release();
    test_ack_races();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
